// File: rtl/conv_window_loader.sv
// conv_window_loader: ping-pong double buffer that assembles a serial pixel stream
// into ROWS x COLS windows, presenting one bank while the other fills.
module conv_window_loader #(
  parameter int ROWS = 14,
  parameter int COLS = 10,
  parameter int DW   = 8
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic [DW-1:0]           in_data,
  input  logic                    in_valid,
  input  logic                    in_sof,
  output logic                    in_ready,
  output logic [0:ROWS*COLS*DW-1] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sof_err
);
  localparam int N = ROWS * COLS;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_st_t;
  bank_st_t st_q [2];
  bank_st_t st_d [2];
  logic [DW-1:0] bank_q [2][N];
  logic [DW-1:0] bank_d [2][N];
  logic wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d, sof_err_q, sof_err_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d, idx;
  logic accept, take, last;
  assign in_ready = rst_b & (st_q[wr_bank_q] != FULL);
  assign out_valid = st_q[rd_bank_q] == FULL;
  assign accept = in_valid & in_ready;
  assign take = out_valid & out_ready;
  assign idx = in_sof ? '0 : wr_cnt_q;
  assign last = idx == LAST;
  assign sof_err = sof_err_q;
  always_comb begin
    out_data = '0;
    for (int k = 0; k < N; k++) out_data[k*DW +: DW] = bank_q[rd_bank_q][k];
  end
  // Release and fill always target different banks, since a FULL bank blocks writes.
  always_comb begin
    st_d = st_q;
    bank_d = bank_q;
    rd_bank_d = take ? ~rd_bank_q : rd_bank_q;
    wr_bank_d = wr_bank_q;
    wr_cnt_d = wr_cnt_q;
    sof_err_d = accept & in_sof & (wr_cnt_q != '0);
    if (take) st_d[rd_bank_q] = EMPTY;
    if (accept) begin
      bank_d[wr_bank_q][idx] = in_data;
      st_d[wr_bank_q] = last ? FULL : FILLING;
      wr_bank_d = wr_bank_q ^ last;
      wr_cnt_d = last ? '0 : idx + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      st_q <= '{default: EMPTY};
      bank_q <= '{default: '0};
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q <= '0;
      sof_err_q <= 1'b0;
    end else begin
      st_q <= st_d;
      bank_q <= bank_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_cnt_q <= wr_cnt_d;
      sof_err_q <= sof_err_d;
    end
  end
endmodule

// File: tb/tb_conv_window_loader.sv
// tb_conv_window_loader: window scoreboard plus directed corner sequences.
`timescale 1ns/1ps
module tb_conv_window_loader;
  localparam int ROWS = 14, COLS = 10, DW = 8, N = ROWS * COLS;
  typedef logic [0:N*DW-1] win_t;
  typedef struct { int t; int k; logic [7:0] e; } vec_t;
  logic clk = 1'b0, rst_b = 1'b0, in_valid = 1'b0, in_sof = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic in_ready, out_valid, sof_err;
  win_t out_data;
  win_t q[$];
  win_t cur = '0;
  int cnt = 0, npop = 0, dpop = 0, nsof = 0, tests = 0, fails = 0;
  logic exp_sof = 1'b0, armed = 1'b0;
  vec_t tv[];

  conv_window_loader #(.ROWS(ROWS), .COLS(COLS), .DW(DW)) dut (
    .clk(clk), .rst_b(rst_b), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .sof_err(sof_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", nm, a, e);
    end
  endtask

  task automatic chk_win(input string nm, input win_t a, input win_t e);
    int k;
    tests++;
    if (a !== e) begin
      fails++;
      k = 0;
      while (k < N - 1 && a[k*DW +: DW] === e[k*DW +: DW]) k++;
      $display("FAIL %s: pixel %0d got %0h required %0h", nm, k, a[k*DW +: DW], e[k*DW +: DW]);
    end
  endtask

  // One clock: drive, check at negedge against the model, advance the model at posedge.
  task automatic step(input logic rb, input logic v, input logic s, input logic r,
                      input logic [7:0] d, output logic acc);
    logic ir, ov, hs;
    int idx;
    rst_b = rb; in_valid = v; in_sof = s; out_ready = r; in_data = d;
    @(negedge clk);
    ir = rb && q.size() < 2;
    ov = q.size() > 0;
    if (armed) begin
      chk("in_ready", in_ready, ir);
      chk("out_valid", out_valid, ov);
      chk("sof_err", sof_err, exp_sof);
      if (ov) chk_win("out_data", out_data, q[0]);
      if (sof_err) nsof++;
      if (out_valid && r) dpop++;
    end
    acc = v && ir;
    hs = ov && r;
    @(posedge clk);
    armed = 1'b1;
    if (!rb) begin
      q.delete();
      cnt = 0;
      exp_sof = 1'b0;
      cur = '0;
    end else begin
      exp_sof = acc && s && cnt != 0;
      if (hs) begin
        void'(q.pop_front());
        npop++;
      end
      if (acc) begin
        idx = s ? 0 : cnt;
        cur[idx*DW +: DW] = d;
        if (idx == N - 1) begin
          q.push_back(cur);
          cnt = 0;
        end else cnt = idx + 1;
      end
    end
    #1;
  endtask

  // mode 0: out_ready=0, 1: out_ready=1, 2: random in_valid/out_ready
  task automatic push(input logic [7:0] d, input logic s, input int mode);
    logic acc = 1'b0;
    int t = 0;
    while (!acc) begin
      if (t++ > 1000) begin
        chk("push_timeout", 1, 0);
        return;
      end
      step(1'b1, mode == 2 ? 1'($urandom_range(0, 3) != 0) : 1'b1, s,
           mode == 0 ? 1'b0 : mode == 1 ? 1'b1 : 1'($urandom_range(0, 1)), d, acc);
    end
  endtask

  task automatic idle(input logic r);
    logic a;
    step(1'b1, 1'b0, 1'b0, r, 8'h00, a);
  endtask

  task automatic do_reset;
    logic a;
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, a);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, a);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sof_err", sof_err, 0);
    chk_win("rst_out_data", out_data, '0);
    nsof = 0; dpop = 0; npop = 0;
  endtask

  task automatic check_table(input int t);
    foreach (tv[i])
      if (tv[i].t == t) chk($sformatf("t%0d_px%0d", t, tv[i].k), out_data[tv[i].k*DW +: DW], tv[i].e);
  endtask

  initial begin
    logic a;
    tv = '{'{1, 0, 8'h00}, '{1, 10, 8'h0A}, '{1, 77, 8'h4D}, '{1, 139, 8'h8B},
           '{3, 0, 8'hAA}, '{3, 1, 8'h01}, '{3, 49, 8'h31}, '{3, 50, 8'h32}, '{3, 139, 8'h8B}};
    do_reset();
    for (int k = 0; k < N; k++) push(8'(k), 1'b0, 0);
    chk("t1_out_valid_after_last", out_valid, 1);
    check_table(1);
    for (int k = N; k < 2 * N; k++) push(8'(k), 1'b0, 0);
    chk("t2_in_ready_both_full", in_ready, 0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, a);
    chk("t2_out_valid_second", out_valid, 1);
    chk("t2_in_ready_after_take", in_ready, 1);
    chk("t2_px0_second", out_data[0 +: DW], 8'h8C);
    for (int i = 0; i < 3; i++) idle(1'b1);
    chk("t12_sof_err_count", nsof, 0);

    do_reset();
    for (int k = 0; k < 50; k++) push(8'hC0 + 8'(k), k == 0, 0);
    push(8'hAA, 1'b1, 0);
    for (int k = 1; k < N; k++) push(8'(k), 1'b0, 0);
    check_table(3);
    for (int i = 0; i < 3; i++) idle(1'b1);
    chk("t3_sof_err_count", nsof, 1);
    chk("t3_windows", dpop, 1);

    do_reset();
    for (int k = 0; k < N; k++) push(8'(k + 7), 1'b0, 0);
    for (int k = 0; k < 70; k++) push(8'(k + 99), 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, a);
    chk("t5_out_valid", out_valid, 0);
    chk("t5_in_ready", in_ready, 0);
    chk_win("t5_out_data", out_data, '0);
    dpop = 0;
    for (int k = 0; k < N; k++) push(8'(3 * k + 1), 1'b0, 0);
    chk("t5_px0", out_data[0 +: DW], 8'h01);
    for (int i = 0; i < 3; i++) idle(1'b1);
    chk("t5_windows", dpop, 1);

    do_reset();
    for (int k = 0; k < 2 * N - 1; k++) push(8'(k), 1'b0, 0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'(2 * N - 1), a);
    chk("t6_accept_on_take", a, 1);
    chk("t6_out_valid", out_valid, 1);
    chk("t6_in_ready", in_ready, 1);
    chk("t6_px0_bank1", out_data[0 +: DW], 8'h8C);
    for (int i = 0; i < 3; i++) idle(1'b1);
    chk("t6_windows", dpop, 2);

    do_reset();
    for (int w = 0; w < 150; w++)
      for (int p = 0; p < N; p++)
        push(8'($urandom), p == 0 ? 1'($urandom_range(0, 1)) : 1'($urandom_range(0, 499) == 0), 2);
    for (int i = 0; i < 6; i++) idle(1'b1);
    chk("t4_pops_vs_model", dpop, npop);
    chk("t4_out_valid_end", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
